// File: rtl/seq_serializer.sv
// seq_serializer: parallel-to-serial stage feeding the serial sequence checkers.
// Words arrive over a valid/ready handshake. They are shifted out MSB-first on
// o_dout, and each bit is held for DIV clocks. A one-word holding register lets
// the next word follow the current one with no idle bits in between.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_clr        synchronous clear: drop the held word and the word in flight
//   i_in_data    word to serialize (sampled only on the accepting edge)
//   i_in_valid   i_in_data is valid
//   o_in_ready   a word can be accepted this cycle (combinational)
//   o_dout       serial bit, MSB first; IDLE_BIT when idle
//   o_dout_vld   strobe on the first clock of each bit period
//   o_busy       a word is being shifted
//   o_word_done  pulse during the last clock of a word's last bit period
module seq_serializer #(
  parameter int   DATA_W   = 8,
  parameter int   DIV      = 1,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_dout,
  output logic              o_dout_vld,
  output logic              o_busy,
  output logic              o_word_done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_PENULT = BW'(DATA_W - 2);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_PENULT = DW'((DIV > 1) ? DIV - 2 : 0);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_sh;
  logic [BW-1:0]     r_bit_cnt;
  logic [DW-1:0]     r_div_cnt;
  logic              r_dout;
  logic              r_dout_vld;
  logic              r_word_done;

  logic w_accept;
  logic w_last_div;
  logic w_last_bit;

  assign o_in_ready = !r_hold_full && !i_clr;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_last_div = (r_div_cnt == DIV_LAST);
  assign w_last_bit = (r_bit_cnt == BIT_LAST);

  assign o_dout      = r_dout;
  assign o_dout_vld  = r_dout_vld;
  assign o_busy      = (r_state == S_SHIFT);
  assign o_word_done = r_word_done;

  // The output flops are loaded with the values for the coming cycle. This
  // makes o_word_done high during the final clock of the word itself.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_sh        <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      r_dout      <= IDLE_BIT;
      r_dout_vld  <= 1'b0;
      r_word_done <= 1'b0;
    end else if (i_clr) begin
      r_state     <= S_IDLE;
      r_hold_full <= 1'b0;
      r_sh        <= '0;
      r_bit_cnt   <= '0;
      r_div_cnt   <= '0;
      r_dout      <= IDLE_BIT;
      r_dout_vld  <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      // o_in_ready is low whenever the holding register is full, so an
      // accept never coincides with a reload below.
      if (w_accept) begin
        r_hold      <= i_in_data;
        r_hold_full <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_word_done <= 1'b0;
          r_dout      <= IDLE_BIT;
          r_dout_vld  <= 1'b0;
          if (r_hold_full) begin
            r_sh        <= r_hold;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_div_cnt   <= '0;
            r_dout      <= r_hold[DATA_W-1];
            r_dout_vld  <= 1'b1;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_last_div) begin
            r_div_cnt   <= r_div_cnt + DW'(1);
            r_dout_vld  <= 1'b0;
            r_word_done <= (DIV > 1) && w_last_bit && (r_div_cnt == DIV_PENULT);
          end else begin
            r_div_cnt <= '0;
            if (!w_last_bit) begin
              r_sh        <= {r_sh[DATA_W-2:0], 1'b0};
              r_bit_cnt   <= r_bit_cnt + BW'(1);
              r_dout      <= r_sh[DATA_W-2];
              r_dout_vld  <= 1'b1;
              r_word_done <= (DIV == 1) && (r_bit_cnt == BIT_PENULT);
            end else begin
              r_word_done <= 1'b0;
              r_bit_cnt   <= '0;
              if (r_hold_full) begin
                // Gapless hand-over: the next MSB goes out on the very next clock.
                r_sh        <= r_hold;
                r_hold_full <= 1'b0;
                r_dout      <= r_hold[DATA_W-1];
                r_dout_vld  <= 1'b1;
              end else begin
                r_dout     <= IDLE_BIT;
                r_dout_vld <= 1'b0;
                r_state    <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] valid = '0;
  logic [1:0] clr = '0;
  logic [7:0] data [2];
  logic [1:0] ready, dout, vld, done, busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Behavioural model: a word in flight is tracked as an elapsed-clock count t.
  // The bit on the line is then word[7 - t/div], and a word lasts 8*div clocks.
  bit       m_act [2] = '{0, 0};
  int       m_t   [2] = '{0, 0};
  bit [7:0] m_word[2] = '{8'h00, 8'h00};
  bit       m_hf  [2] = '{0, 0};
  bit [7:0] m_hold[2] = '{8'h00, 8'h00};

  bit bq0[$], bq1[$];
  int dq0[$], dq1[$];
  int fv0 = -1;

  always #5 clk = ~clk;

  seq_serializer #(.DATA_W(8), .DIV(1), .IDLE_BIT(1'b0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr[0]), .i_in_data(data[0]), .i_in_valid(valid[0]),
    .o_in_ready(ready[0]), .o_dout(dout[0]), .o_dout_vld(vld[0]), .o_busy(busy[0]),
    .o_word_done(done[0]));

  seq_serializer #(.DATA_W(8), .DIV(3), .IDLE_BIT(1'b0)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr[1]), .i_in_data(data[1]), .i_in_valid(valid[1]),
    .o_in_ready(ready[1]), .o_dout(dout[1]), .o_dout_vld(vld[1]), .o_busy(busy[1]),
    .o_word_done(done[1]));

  function automatic int div_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst || clr[d]) begin
        m_act[d] = 0; m_hf[d] = 0; m_t[d] = 0;
      end else begin
        bit       acc;
        bit [7:0] ad;
        acc = valid[d] && !m_hf[d];
        ad  = data[d];
        if (m_act[d]) begin
          m_t[d] = m_t[d] + 1;
          if (m_t[d] == 8 * div_of(d)) begin
            if (m_hf[d]) begin m_word[d] = m_hold[d]; m_hf[d] = 0; m_t[d] = 0; end
            else m_act[d] = 0;
          end
        end else if (m_hf[d]) begin
          m_word[d] = m_hold[d]; m_hf[d] = 0; m_act[d] = 1; m_t[d] = 0;
        end
        if (acc) begin m_hold[d] = ad; m_hf[d] = 1; end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic e_dout, e_vld, e_done, e_busy, e_rdy;
      if (rst) begin
        e_dout = 0; e_vld = 0; e_done = 0; e_busy = 0; e_rdy = !clr[d];
      end else begin
        e_busy = m_act[d];
        e_dout = m_act[d] ? m_word[d][7 - m_t[d] / div_of(d)] : 1'b0;
        e_vld  = m_act[d] && (m_t[d] % div_of(d) == 0);
        e_done = m_act[d] && (m_t[d] == 8 * div_of(d) - 1);
        e_rdy  = !m_hf[d] && !clr[d];
      end
      chk($sformatf("dout[%0d]", d), dout[d], e_dout);
      chk($sformatf("dout_vld[%0d]", d), vld[d], e_vld);
      chk($sformatf("word_done[%0d]", d), done[d], e_done);
      chk($sformatf("busy[%0d]", d), busy[d], e_busy);
      chk($sformatf("in_ready[%0d]", d), ready[d], e_rdy);
    end
    if (!rst) begin
      if (vld[0]) begin bq0.push_back(dout[0]); if (fv0 < 0) fv0 = cyc; end
      if (vld[1]) bq1.push_back(dout[1]);
      if (done[0]) dq0.push_back(cyc);
      if (done[1]) dq1.push_back(cyc);
    end
  end

  function automatic logic [31:0] packq(input int d);
    logic [31:0] v = '0;
    if (d == 0) foreach (bq0[i]) v = {v[30:0], bq0[i]};
    else        foreach (bq1[i]) v = {v[30:0], bq1[i]};
    return v;
  endfunction

  task automatic clear_logs();
    bq0.delete(); bq1.delete(); dq0.delete(); dq1.delete(); fv0 = -1;
  endtask

  // Hold a word on the bus until accepted. While the block is not ready,
  // in_data is scrambled to show that it is ignored until the accepting edge.
  task automatic send(input int d, input logic [7:0] w, output int k);
    bit r;
    valid[d] = 1'b1; data[d] = w; k = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      r = ready[d];
      data[d] = r ? w : 8'($urandom);
      @(posedge clk); #1;
      if (r) begin k = cyc; break; end
    end
    if (k < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int d);
    bit ok = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (!busy[d] && ready[d]) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int d);
    for (int i = 0; i < 2000; i++) begin
      int p;
      p = ((i / 150) % 2 == 1) ? 85 : 8;
      valid[d] = ($urandom_range(0, 99) < p);
      data[d]  = 8'($urandom);
      clr[d]   = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    valid[d] = 0; clr[d] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, k3;
    data[0] = 8'h00; data[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_dout", dout[0], 0);
    chk("rst_vld", vld[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_ready", ready[0], 1);
    @(posedge clk); #1;

    // Single word
    clear_logs();
    send(0, 8'hD0, k);
    valid[0] = 0;
    wait_idle(0);
    chk("d0_bits", packq(0), 32'h0000_00D0);
    chk("d0_nbits", bq0.size(), 8);
    chk("d0_first_vld", fv0, k + 1);
    chk("d0_ndone", dq0.size(), 1);
    if (dq0.size() > 0) chk("d0_done_cyc", dq0[0], k + 8);

    // Back-to-back
    clear_logs();
    send(0, 8'hD0, k);
    send(0, 8'hB5, k2);
    valid[0] = 0;
    wait_idle(0);
    chk("b2b_bits", packq(0), 32'h0000_D0B5);
    chk("b2b_ndone", dq0.size(), 2);
    if (dq0.size() > 1) begin
      chk("b2b_done1", dq0[0], k + 8);
      chk("b2b_done2", dq0[1], k + 16);
    end

    // Backpressure: three words queued with valid held high
    clear_logs();
    send(0, 8'h11, k);
    send(0, 8'h22, k2);
    send(0, 8'h33, k3);
    valid[0] = 0;
    wait_idle(0);
    chk("bp_bits", packq(0), 32'h0011_2233);
    chk("bp_nbits", bq0.size(), 24);
    chk("bp_ndone", dq0.size(), 3);

    // DIV=3
    clear_logs();
    send(1, 8'hA5, k);
    valid[1] = 0;
    wait_idle(1);
    chk("div3_bits", packq(1), 32'h0000_00A5);
    chk("div3_nstrobes", bq1.size(), 8);
    chk("div3_ndone", dq1.size(), 1);
    if (dq1.size() > 0) chk("div3_done_cyc", dq1[0], k + 24);

    // clr on the 4th bit of 8'hFF with 8'h0F held
    clear_logs();
    send(0, 8'hFF, k);
    send(0, 8'h0F, k2);
    valid[0] = 0;
    for (int n = 0; n < 50 && cyc < k + 4; n++) begin @(posedge clk); #1; end
    clr[0] = 1;
    @(posedge clk); #1;
    clr[0] = 0;
    @(negedge clk);
    chk("clr_dout", dout[0], 0);
    chk("clr_busy", busy[0], 0);
    chk("clr_ready", ready[0], 1);
    chk("clr_done", done[0], 0);
    repeat (20) @(posedge clk);
    #1;
    chk("clr_nbits", bq0.size(), 4);
    chk("clr_bits", packq(0), 32'h0000_000F);
    chk("clr_ndone", dq0.size(), 0);

    // Asynchronous reset mid-word
    send(0, 8'hC3, k);
    valid[0] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_dout", dout[0], 0);
    chk("arst_vld", vld[0], 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_done", done[0], 0);
    chk("arst_ready", ready[0], 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_logs();
    repeat (12) @(posedge clk);
    #1;
    chk("arst_no_bits", bq0.size(), 0);

    // Randomized traffic on both instances
    fork
      rand_run(0);
      rand_run(1);
    join
    repeat (40) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
Parallel-to-serial stage that sits directly upstream of the serial sequence-check FSMs. It accepts DATA_W-bit words through a valid/ready handshake and shifts them out MSB-first on a single-bit stream (dout). It also produces a per-bit strobe, so the downstream detector receives exactly one bit per bit period. A one-word holding register lets consecutive words stream back-to-back with no idle bits between them.

Parameters:
DATA_W, 8, word width in bits (>=2)
DIV, 1, clocks per serial bit (>=1); DIV=1 gives one bit per clk
IDLE_BIT, 1'b0, dout level while no word is being shifted

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear: discard held and in-flight words
in_data  in  DATA_W  word to serialize
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a word this cycle
dout  out  1  serial bit, MSB first
dout_vld  out  1  one-cycle strobe on the first clk of each bit period
busy  out  1  a word is being shifted
word_done  out  1  one-cycle pulse at the end of a word's last bit period

Behaviour:
- Reset (rst=1, async): state=IDLE, hold_full=0, shift reg=0, bit_cnt=0, div_cnt=0. Outputs: dout=IDLE_BIT, dout_vld=0, busy=0, word_done=0, in_ready=1 once clr=0.
- All outputs are driven from registers. in_ready is the only combinational output: in_ready = !hold_full && !clr. There is no combinational path from in_data to dout.
- Accept: when in_valid && in_ready at an edge, hold <= in_data and hold_full <= 1.
- The FSM has two states, IDLE and SHIFT.
- IDLE:
  - dout=IDLE_BIT, dout_vld=0, busy=0.
  - If hold_full: sh <= hold, hold_full <= 0, bit_cnt <= 0, div_cnt <= 0, go to SHIFT.
- SHIFT:
  - dout = sh[DATA_W-1], busy=1.
  - dout_vld=1 exactly when div_cnt==0.
  - div_cnt counts 0..DIV-1 and then wraps.
  - At div_cnt==DIV-1 with bit_cnt<DATA_W-1: shift sh left by one, bit_cnt++.
  - At div_cnt==DIV-1 with bit_cnt==DATA_W-1: word_done=1 for that cycle. Then:
    - if hold_full: reload sh from hold, clear hold_full, bit_cnt=0, stay in SHIFT. This is gapless: the next MSB appears on the very next clk.
    - else: go to IDLE.
- Latency: with the word accepted at edge k, hold_full=1 after edge k. After edge k+1 the block is in SHIFT with dout=MSB and dout_vld=1. Each word occupies exactly DATA_W*DIV clks in SHIFT.
- Holding register:
  - While a word is shifting, the holding register may be filled, so in_ready=1 during SHIFT until a word is accepted.
  - in_ready drops the cycle after acceptance and returns the cycle after the reload.
- Simultaneous events:
  - A reload and an acceptance cannot coincide, because in_ready=0 whenever hold_full=1.
  - clr has priority over every other event. On the next edge: hold_full=0, state=IDLE, counters=0, dout=IDLE_BIT.
  - An in_valid presented in the same cycle as clr is not accepted (in_ready=0).
  - word_done is not asserted for a word aborted by clr.
- rst mid-word: immediate return to the reset values. The partial word and the held word are lost.
- Widths:
  - bit_cnt is $clog2(DATA_W) bits; div_cnt is max(1,$clog2(DIV)) bits.
  - Counters never exceed DATA_W-1 and DIV-1 respectively.
- in_data is sampled only on the accepting edge. Changes to in_data at any other time have no effect.

Test Plan:
- Reset then idle (DATA_W=8, DIV=1): hold rst=1 for 3 clks, release -> dout=0, dout_vld=0, busy=0, word_done=0, in_ready=1. Applying rst mid-word returns all outputs to these values asynchronously.
- Single word 8'hD0, DIV=1: accept at edge k -> dout = 1,1,0,1,0,0,0,0 on clks k+1..k+8, dout_vld=1 on each of those clks, word_done=1 on clk k+8, busy=0 from k+9.
- Back-to-back 8'hD0 then 8'hB5, second word presented during the first -> 16 contiguous bits 11010000_10110101, no idle gap, word_done on clks k+8 and k+16. in_ready=0 from acceptance of 8'hB5 until the reload.
- Backpressure: hold in_valid=1 with 3 words queued while the holding register is full -> in_ready=0 and in_data is ignored. Each word is accepted exactly once, in order.
- DIV=3, word 8'hA5: each bit is held 3 clks (24 clks total), dout_vld high only on the first clk of each bit, word_done on the 24th clk.
- clr asserted on the 4th bit of 8'hFF, with 8'h0F held -> next clk dout=IDLE_BIT, busy=0, in_ready=1, no word_done, and 8'h0F is never emitted.
